// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons with shared configuration,
// a global saturating spike counter and a membrane observation mux.
// Each channel integrates its input current on step strobes. It fires when the
// saturated membrane sum reaches the threshold. After firing it stays silent for
// a programmable number of steps.
module lif_neuron_array #(
  parameter int N_CH     = 4,
  parameter int IN_W     = 8,
  parameter int MEM_W    = 10,
  parameter int REFRAC_W = 3,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic [N_CH*IN_W-1:0]   in_flat,
  input  logic [MEM_W-1:0]       threshold,
  input  logic [2:0]             leak_shift,
  input  logic [REFRAC_W-1:0]    refrac_period,
  input  logic                   sub_mode,
  input  logic                   count_clr,
  input  logic [SEL_W-1:0]       mem_sel,
  output logic [N_CH-1:0]        spike,
  output logic                   spike_any,
  output logic [CNT_W-1:0]       spike_count,
  output logic [MEM_W-1:0]       mem_out
);

  localparam int POP_W = $clog2(N_CH + 1);
  localparam int SEL_N = 2 ** SEL_W;

  logic [N_CH-1:0]       spike_d;
  logic [N_CH-1:0]       spike_q;
  logic                  spike_any_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [CNT_W:0]        count_sum;
  logic [POP_W-1:0]      pop;
  logic [N_CH*MEM_W-1:0] mem_flat;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [MEM_W-1:0]    mem_q;
    logic [MEM_W-1:0]    mem_d;
    logic [REFRAC_W-1:0] refrac_q;
    logic [REFRAC_W-1:0] refrac_d;
    logic                spike_k_d;
    logic [IN_W-1:0]     in_k;
    logic [MEM_W-1:0]    leaked;
    logic [MEM_W:0]      sum_raw;
    logic [MEM_W-1:0]    sum_sat;

    assign in_k    = in_flat[gi*IN_W +: IN_W];
    // leak_shift = 0 removes the whole membrane (mem - mem = 0)
    assign leaked  = mem_q - (mem_q >> leak_shift);
    // One extra bit catches the overflow so the sum can clamp instead of wrapping
    assign sum_raw = {1'b0, leaked} + {{(MEM_W + 1 - IN_W){1'b0}}, in_k};
    assign sum_sat = sum_raw[MEM_W] ? {MEM_W{1'b1}} : sum_raw[MEM_W-1:0];

    // Next-state for one channel: refractory countdown, integrate, or fire
    always_comb begin
      mem_d     = mem_q;
      refrac_d  = refrac_q;
      spike_k_d = 1'b0;
      if (step) begin
        if (refrac_q != '0) begin
          refrac_d = refrac_q - REFRAC_W'(1);
        end else if (sum_sat >= threshold) begin
          spike_k_d = 1'b1;
          refrac_d  = refrac_period;
          mem_d     = sub_mode ? (sum_sat - threshold) : '0;
        end else begin
          mem_d = sum_sat;
        end
      end
    end

    // Channel state registers
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q    <= '0;
        refrac_q <= '0;
      end else begin
        mem_q    <= mem_d;
        refrac_q <= refrac_d;
      end
    end

    assign spike_d[gi]                 = spike_k_d;
    assign mem_flat[gi*MEM_W +: MEM_W] = mem_q;
  end

  // Number of channels firing on this edge
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + POP_W'(spike_d[i]);
    end
  end

  // Counter adds the new spikes and clamps at all-ones; clear wins over counting
  assign count_sum = {1'b0, count_q} + (CNT_W + 1)'(pop);
  assign count_d   = count_clr ? '0 :
                     (count_sum[CNT_W] ? {CNT_W{1'b1}} : count_sum[CNT_W-1:0]);

  // Spike outputs and global counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_q     <= '0;
      spike_any_q <= 1'b0;
      count_q     <= '0;
    end else begin
      spike_q     <= spike_d;
      spike_any_q <= |spike_d;
      count_q     <= count_d;
    end
  end

  // Observation mux; select codes beyond the last channel read as zero
  logic [SEL_N-1:0][MEM_W-1:0] mem_pad;
  for (genvar gi = 0; gi < SEL_N; gi++) begin : g_pad
    if (gi < N_CH) begin : g_used
      assign mem_pad[gi] = mem_flat[gi*MEM_W +: MEM_W];
    end else begin : g_unused
      assign mem_pad[gi] = '0;
    end
  end

  assign mem_out     = mem_pad[mem_sel];
  assign spike       = spike_q;
  assign spike_any   = spike_any_q;
  assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed testbench for lif_neuron_array (4 channels, default widths).
// A table of per-cycle vectors covers integration, subtract mode, leak,
// saturation, refractory gating and multi-channel counting. Hand-written
// sequences then cover the observation mux, reset mid-count and counter saturation.
module tb_lif_neuron_array;

  logic        clk;
  logic        reset;
  logic        step;
  logic [31:0] in_flat;
  logic [9:0]  threshold;
  logic [2:0]  leak_shift;
  logic [2:0]  refrac_period;
  logic        sub_mode;
  logic        count_clr;
  logic [1:0]  mem_sel;
  logic [3:0]  spike;
  logic        spike_any;
  logic [15:0] spike_count;
  logic [9:0]  mem_out;

  int checks = 0;
  int errors = 0;

  lif_neuron_array #(
    .N_CH(4), .IN_W(8), .MEM_W(10), .REFRAC_W(3), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .in_flat(in_flat),
    .threshold(threshold), .leak_shift(leak_shift), .refrac_period(refrac_period),
    .sub_mode(sub_mode), .count_clr(count_clr), .mem_sel(mem_sel),
    .spike(spike), .spike_any(spike_any), .spike_count(spike_count), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stp;
    logic [31:0] inf;
    logic [9:0]  thr;
    logic [2:0]  ls;
    logic [2:0]  rp;
    logic        sm;
    logic        clr;
    logic [1:0]  sel;
    logic [3:0]  e_spk;
    logic [15:0] e_cnt;
    logic [9:0]  e_mem;
  } vec_t;

  vec_t vecs[$];

  logic [9:0] cfg_thr;
  logic [2:0] cfg_ls;
  logic [2:0] cfg_rp;
  logic       cfg_sm;

  task automatic add(input logic r, input logic s, input logic [31:0] inf,
                     input logic c, input logic [1:0] sel,
                     input logic [3:0] es, input int ec, input int em);
    vec_t v;
    v.rst = r; v.stp = s; v.inf = inf; v.clr = c; v.sel = sel;
    v.thr = cfg_thr; v.ls = cfg_ls; v.rp = cfg_rp; v.sm = cfg_sm;
    v.e_spk = es; v.e_cnt = ec[15:0]; v.e_mem = em[9:0];
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; in_flat = '0; threshold = '0; leak_shift = '0;
    refrac_period = '0; sub_mode = 1'b0; count_clr = 1'b0; mem_sel = '0;

    // Integrate, reset-to-zero mode
    cfg_thr = 10'd100; cfg_ls = 3'd7; cfg_rp = 3'd0; cfg_sm = 1'b0;
    add(1, 1, 32'd30, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 30);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 60);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 90);
    add(0, 1, 32'd30, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 32'd30, 0, 0, 4'b0000, 1, 0);

    // Subtract mode
    cfg_sm = 1'b1;
    add(1, 1, 32'd30, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 30);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 60);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 0, 90);
    add(0, 1, 32'd30, 0, 0, 4'b0001, 1, 20);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 1, 50);
    add(0, 1, 32'd30, 0, 0, 4'b0000, 1, 80);
    add(0, 1, 32'd30, 0, 0, 4'b0001, 2, 10);

    // Leak converges to 80, then full leak with leak_shift = 0
    cfg_sm = 1'b0; cfg_ls = 3'd1;
    add(1, 0, 32'd40, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 40);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 60);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 70);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 75);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 78);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 79);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 80);
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 80);
    cfg_ls = 3'd0;
    add(0, 1, 32'd40, 0, 0, 4'b0000, 0, 40);

    // Membrane saturation at 1023
    cfg_thr = 10'd1023; cfg_ls = 3'd7;
    add(1, 0, 32'd255, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 32'd255, 0, 0, 4'b0000, 0, 255);
    add(0, 1, 32'd255, 0, 0, 4'b0000, 0, 509);
    add(0, 1, 32'd255, 0, 0, 4'b0000, 0, 761);
    add(0, 1, 32'd255, 0, 0, 4'b0000, 0, 1011);
    add(0, 1, 32'd255, 0, 0, 4'b0001, 1, 0);

    // Refractory period of 2 with step gating in the middle
    cfg_thr = 10'd100; cfg_rp = 3'd2; cfg_sm = 1'b1;
    add(1, 0, 32'd150, 0, 0, 4'b0000, 0, 0);
    add(0, 1, 32'd150, 0, 0, 4'b0001, 1, 50);
    add(0, 1, 32'd150, 0, 0, 4'b0000, 1, 50);
    add(0, 1, 32'd150, 0, 0, 4'b0000, 1, 50);
    add(0, 1, 32'd150, 0, 0, 4'b0001, 2, 100);
    add(0, 0, 32'd150, 0, 0, 4'b0000, 2, 100);
    add(0, 0, 32'd150, 0, 0, 4'b0000, 2, 100);
    add(0, 1, 32'd150, 0, 0, 4'b0000, 2, 100);
    add(0, 1, 32'd150, 0, 0, 4'b0000, 2, 100);
    add(0, 1, 32'd150, 0, 0, 4'b0001, 3, 150);

    // Independent channels, all-channel spikes and count_clr
    cfg_thr = 10'd50; cfg_rp = 3'd0; cfg_sm = 1'b0;
    add(1, 0, 32'h00_32_1E_3C, 0, 1, 4'b0000, 0, 0);
    add(0, 1, 32'h00_32_1E_3C, 0, 1, 4'b0101, 2, 30);
    add(0, 1, 32'h00_32_1E_3C, 0, 1, 4'b0111, 5, 0);
    cfg_thr = 10'd0;
    add(0, 1, 32'h00_32_1E_3C, 0, 3, 4'b1111, 9, 0);
    add(0, 1, 32'h00_32_1E_3C, 1, 3, 4'b1111, 0, 0);
    add(0, 1, 32'h00_32_1E_3C, 0, 2, 4'b1111, 4, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; step = vecs[i].stp; in_flat = vecs[i].inf;
      threshold = vecs[i].thr; leak_shift = vecs[i].ls; refrac_period = vecs[i].rp;
      sub_mode = vecs[i].sm; count_clr = vecs[i].clr; mem_sel = vecs[i].sel;
      tick();
      check("spike", i, int'(spike), int'(vecs[i].e_spk));
      check("spike_any", i, int'(spike_any), int'(|vecs[i].e_spk));
      check("spike_count", i, int'(spike_count), int'(vecs[i].e_cnt));
      check("mem_out", i, int'(mem_out), int'(vecs[i].e_mem));
      $display("row %0d rst=%0b step=%0b spike=%b count=%0d mem[%0d]=%0d",
               i, vecs[i].rst, vecs[i].stp, spike, spike_count, mem_sel, mem_out);
    end

    // Distinct membranes per channel, then reset overriding step mid-count
    reset = 1'b0; step = 1'b1; count_clr = 1'b0; threshold = 10'd1023;
    in_flat = {8'd103, 8'd102, 8'd101, 8'd100};
    tick();
    step = 1'b0;
    check("hold_count", 100, int'(spike_count), 4);
    for (int k = 0; k < 4; k++) begin
      mem_sel = k[1:0];
      #1;
      check("mem_sel", 100 + k, int'(mem_out), 100 + k);
      $display("mux sel=%0d mem=%0d", k, mem_out);
    end
    reset = 1'b1; step = 1'b1; threshold = 10'd0;
    tick();
    check("rst_spike", 110, int'(spike), 0);
    check("rst_any", 110, int'(spike_any), 0);
    check("rst_count", 110, int'(spike_count), 0);
    for (int k = 0; k < 4; k++) begin
      mem_sel = k[1:0];
      #1;
      check("rst_mem", 110 + k, int'(mem_out), 0);
    end
    $display("reset mid-count: spike=%b count=%0d", spike, spike_count);

    // Counter saturation: four spikes per step until the 16-bit cap
    reset = 1'b0; step = 1'b1; in_flat = '0; threshold = 10'd0;
    refrac_period = 3'd0; sub_mode = 1'b0;
    repeat (16383) @(posedge clk);
    #1;
    check("cnt_near_cap", 120, int'(spike_count), 65532);
    check("cnt_spike", 120, int'(spike), 15);
    $display("count after 16383 steps = %0d", spike_count);
    tick();
    check("cnt_cap", 121, int'(spike_count), 65535);
    $display("count at cap = %0d", spike_count);
    tick();
    check("cnt_hold_cap", 122, int'(spike_count), 65535);
    check("cnt_hold_spike", 122, int'(spike), 15);
    $display("count held at cap = %0d", spike_count);
    count_clr = 1'b1;
    tick();
    check("cnt_clr", 123, int'(spike_count), 0);
    $display("count after clear = %0d", spike_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- Parametrised successor to the single 8-bit spiking neuron: N_CH independent leaky integrate-and-fire (LIF) neurons.
- Each neuron has a programmable threshold, shift-based leak, refractory period and post-spike reset mode.
- Sits behind the TinyTapeout top; ui_in/uio_in supply input currents and config, and spikes drive uo_out.
- Adds a global saturating spike counter and a membrane-observation mux for debug.

Parameters:
- N_CH, 4, number of neuron channels (1..8).
- IN_W, 8, width of each unsigned input current; must be <= MEM_W.
- MEM_W, 10, width of each unsigned membrane potential.
- REFRAC_W, 3, width of the refractory period and counter.
- CNT_W, 16, width of the global spike counter.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- step  input  1  integration strobe; state advances only on cycles with step=1.
- in_flat  input  N_CH*IN_W  input currents; channel k occupies bits [k*IN_W +: IN_W].
- threshold  input  MEM_W  firing threshold, shared by all channels.
- leak_shift  input  3  leak amount = mem >> leak_shift.
- refrac_period  input  REFRAC_W  number of steps a channel is silent after a spike.
- sub_mode  input  1  0 = reset membrane to 0 on spike; 1 = subtract threshold on spike.
- count_clr  input  1  clears spike_count.
- mem_sel  input  $clog2(N_CH) (min 1)  channel selected for mem_out.
- spike  output  N_CH  registered one-cycle spike pulses.
- spike_any  output  1  registered OR of spike.
- spike_count  output  CNT_W  saturating total spike count.
- mem_out  output  MEM_W  membrane of channel mem_sel (combinational mux of the registered state).

Behaviour:
- Reset: every mem, refrac counter, spike, spike_any and spike_count goes to 0 on the same edge. Reset overrides step and count_clr, including mid-integration.
- step=0: mem and refrac counters hold; spike and spike_any are 0 on the next cycle.
- step=1, per channel k, when refrac_k > 0:
  - refrac_k <= refrac_k - 1.
  - mem_k held at its current value; input ignored; no spike.
- step=1, per channel k, when refrac_k == 0:
  - leaked = mem_k - (mem_k >> leak_shift). leak_shift=0 therefore gives leaked=0 (full leak).
  - sum = leaked + in_k, computed at MEM_W+1 bits, then saturated to 2^MEM_W-1.
  - If sum >= threshold:
    - spike_k <= 1.
    - refrac_k <= refrac_period.
    - mem_k <= 0 when sub_mode=0, else sum - threshold.
  - Otherwise: mem_k <= sum and spike_k <= 0.
- Latency: one cycle. A spike caused by the inputs sampled at edge n is visible after edge n, for one cycle only.
- threshold=0: every non-refractory step spikes. refrac_period=0: no refractory gap.
- Config inputs are sampled every step with no shadowing. A change takes effect on the next step.
- spike_count update on each edge:
  - Adds popcount of the newly registered spike vector, so it is visible in the same cycle as the spikes.
  - Saturates at 2^CNT_W-1.
  - count_clr=1 forces 0; spikes in that cycle are not counted.
- Channels are fully independent, and simultaneous spikes on all channels are legal. Spikes arriving while the counter is near saturation add up to the cap and then hold.

Test Plan:
- Integrate: reset 1 cycle; then threshold=100, leak_shift=7, refrac=0, sub_mode=0, ch0 in=30, step every cycle -> mem0 = 30, 60, 90, then spike0 pulses on step 4 with mem0=0; spike_count=1.
- Subtract mode: same stimulus with sub_mode=1 -> step-4 spike leaves mem0=20; the next spike occurs on step 7 (50, 80, 110 -> spike, mem0=10).
- Leak: threshold=100, leak_shift=1, in=40 -> mem0 = 40, 60, 70, 75, 78, 79, 80, then stays at 80; no spike ever.
- Saturation: MEM_W=10, threshold=1023, leak_shift=7, in=255 -> mem0 = 255, 509, 761, 1011, then the 5th step saturates to 1023 and spikes.
- Refractory and gating:
  - refrac=2, in=150, threshold=100 -> spike, then two steps with no spike and mem held.
  - The spike repeats every 3rd step.
  - Holding step=0 freezes mem and refrac.
- All-channel spike + count_clr + reset:
  - All 4 channels spike in one cycle -> spike_count += 4 and spike_any=1.
  - Asserting count_clr in that same cycle -> spike_count=0.
  - Asserting reset mid-count -> all state cleared on the next edge.
